// File: rtl/addsub_acc_unit.sv
// addsub_acc_unit: registered WIDTH-bit add/sub/carry-chain/accumulate ALU slice with status flags.
// Latency: 1 cycle from accept (in_valid && in_ready) to out_valid; 1 op/cycle sustained.
// Backpressure: in_ready = !out_valid || out_ready; while out_valid && !out_ready all outputs hold and nothing is accepted.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (op, a, b, cin)
//   op                    0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 ACC, 5 CLR, 6/7 PASS
//   out_valid/out_ready   result handshake (sum, cout, ovf, zero, neg)
//   acc                   live accumulator value
module addsub_acc_unit #(
    parameter int WIDTH = 4,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic [WIDTH-1:0] acc
);

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_ADC = OPW'(2);
    localparam logic [OPW-1:0] OP_SBC = OPW'(3);
    localparam logic [OPW-1:0] OP_ACC = OPW'(4);
    localparam logic [OPW-1:0] OP_CLR = OPW'(5);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;
    logic [WIDTH-1:0] r_acc;
    logic             r_cf;

    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;
    logic             w_ci;
    logic             w_arith;
    logic [WIDTH:0]   w_full;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_ovf;
    logic             w_acc_ld;

    // Gated by rst_n so the producer sees "not ready" for the whole reset window.
    assign w_in_ready = rst_n && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;

    // One shared WIDTH+1 adder; subtracts are a + ~b + carry, so cout = 1 means no borrow.
    always_comb begin
        w_opa    = a;
        w_opb    = b;
        w_ci     = 1'b0;
        w_arith  = 1'b1;
        w_acc_ld = 1'b0;
        case (op)
            OP_ADD: w_ci = cin;
            OP_SUB: begin
                w_opb = ~b;
                w_ci  = 1'b1;
            end
            OP_ADC: w_ci = r_cf;
            OP_SBC: begin
                w_opb = ~b;
                w_ci  = r_cf;
            end
            OP_ACC: begin
                w_opa    = r_acc;
                w_opb    = a;
                w_acc_ld = 1'b1;
            end
            OP_CLR: begin
                w_arith  = 1'b0;
                w_acc_ld = 1'b1;
            end
            default: w_arith = 1'b0;
        endcase

        w_full = {1'b0, w_opa} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_ci};

        if (w_arith) begin
            w_res = w_full[WIDTH-1:0];
            w_c   = w_full[WIDTH];
            // Signed overflow: both addends share a sign the result does not.
            w_ovf = (w_opa[WIDTH-1] == w_opb[WIDTH-1]) &&
                    (w_full[WIDTH-1] != w_opa[WIDTH-1]);
        end else begin
            w_res = (op == OP_CLR) ? '0 : a;
            w_c   = 1'b0;
            w_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b1;
            r_neg       <= 1'b0;
            r_acc       <= '0;
            r_cf        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_sum       <= w_res;
                r_cout      <= w_c;
                r_ovf       <= w_ovf;
                r_zero      <= (w_res == '0);
                r_neg       <= w_res[WIDTH-1];
                // Carry flag follows every accepted op so multi-word chains see the previous word.
                r_cf        <= w_c;
                if (w_acc_ld) begin
                    r_acc <= w_res;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign acc       = r_acc;

endmodule

// File: tb/tb_addsub_acc_unit.sv
module tb_addsub_acc_unit;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         neg;
        logic [W-1:0] acc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
    logic [W-1:0] acc;

    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int popped = 0;
    int run_len = 0;
    int max_run = 0;

    exp_t  exp_q[$];
    string name_q[$];

    addsub_acc_unit #(.WIDTH(W), .OPW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg),
        .acc       (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic v,
                                input logic [W-1:0] ac);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = v;
        e.zero = (s == 4'h0);
        e.neg  = s[W-1];
        e.acc  = ac;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Drive one op, wait (bounded) for acceptance, push the hand-computed response.
    task automatic issue(input string nm, input logic [2:0] o, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input logic ic, input exp_t e);
        int waited;
        op       = o;
        a        = ia;
        b        = ib;
        cin      = ic;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s: not accepted within 50 cycles (in_ready=%b)", nm, in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back(e);
            name_q.push_back(nm);
            pushed++;
            #1 in_valid = 1'b0;
        end
    endtask

    // Monitor: a result is consumed when out_valid && out_ready at the sampling point.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (out_valid && out_ready) begin
                exp_t  e;
                exp_t  g;
                string nm;
                g = '{sum: sum, cout: cout, ovf: ovf, zero: zero, neg: neg, acc: acc};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h with nothing expected", g);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    popped++;
                    if (g !== e) begin
                        errors++;
                        $display("FAIL %s: got sum=%h c=%b v=%b z=%b n=%b acc=%h, expected sum=%h c=%b v=%b z=%b n=%b acc=%h",
                                 nm, g.sum, g.cout, g.ovf, g.zero, g.neg, g.acc,
                                 e.sum, e.cout, e.ovf, e.zero, e.neg, e.acc);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'd0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", {3'b0, out_valid}, 4'h0);
        chk("rst_in_ready",  {3'b0, in_ready},  4'h0);
        chk("rst_zero",      {3'b0, zero},      4'h1);
        chk("rst_sum",       sum,               4'h0);
        chk("rst_acc",       acc,               4'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add/sub and flags
        issue("add_ovf",   3'd0, 4'h7, 4'h1, 1'b1, mk(4'h9, 1'b0, 1'b1, 4'h0));
        issue("add_carry", 3'd0, 4'hF, 4'hF, 1'b1, mk(4'hF, 1'b1, 1'b0, 4'h0));
        issue("sub_borrow",3'd1, 4'h3, 4'h5, 1'b0, mk(4'hE, 1'b0, 1'b0, 4'h0));
        issue("sub_zero",  3'd1, 4'h5, 4'h5, 1'b0, mk(4'h0, 1'b1, 1'b0, 4'h0));

        // 8-bit chain 0x2F + 0x1E = 0x4D, then SBC sees cf=0
        issue("chain_lo",  3'd0, 4'hF, 4'hE, 1'b0, mk(4'hD, 1'b1, 1'b0, 4'h0));
        issue("chain_hi",  3'd2, 4'h2, 4'h1, 1'b0, mk(4'h4, 1'b0, 1'b0, 4'h0));
        issue("sbc_cf0",   3'd3, 4'h5, 4'h2, 1'b1, mk(4'h2, 1'b1, 1'b0, 4'h0));

        // Accumulator
        issue("clr",       3'd5, 4'h9, 4'h9, 1'b1, mk(4'h0, 1'b0, 1'b0, 4'h0));
        issue("acc5",      3'd4, 4'h5, 4'hA, 1'b1, mk(4'h5, 1'b0, 1'b0, 4'h5));
        issue("accC",      3'd4, 4'hC, 4'h3, 1'b0, mk(4'h1, 1'b1, 1'b0, 4'h1));
        op = 3'd4; a = 4'h3; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("acc_no_valid", acc, 4'h1);
        issue("pass",      3'd6, 4'h9, 4'h3, 1'b1, mk(4'h9, 1'b0, 1'b0, 4'h1));

        // Backpressure: hold result, pending SUB must wait
        issue("bp_add",    3'd0, 4'h2, 4'h3, 1'b0, mk(4'h5, 1'b0, 1'b0, 4'h1));
        out_ready = 1'b0;
        op = 3'd1; a = 4'h6; b = 4'h2; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {3'b0, in_ready},  4'h0);
            chk("bp_valid",    {3'b0, out_valid}, 4'h1);
            chk("bp_sum",      sum,               4'h5);
            chk("bp_acc",      acc,               4'h1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        issue("bp_sub",    3'd1, 4'h6, 4'h2, 1'b0, mk(4'h4, 1'b1, 1'b0, 4'h1));

        // Streaming: exactly 4 consecutive valid cycles
        repeat (3) @(posedge clk);
        #1;
        max_run = 0;
        issue("st_add",    3'd0, 4'h1, 4'h1, 1'b0, mk(4'h2, 1'b0, 1'b0, 4'h1));
        issue("st_sub",    3'd1, 4'h4, 4'h1, 1'b0, mk(4'h3, 1'b1, 1'b0, 4'h1));
        issue("st_adc",    3'd2, 4'h1, 4'h1, 1'b0, mk(4'h3, 1'b0, 1'b0, 4'h1));
        issue("st_pass",   3'd7, 4'h0, 4'hF, 1'b1, mk(4'h0, 1'b0, 1'b0, 4'h1));
        repeat (3) @(posedge clk);
        #1 chk("stream_run", 4'(max_run), 4'h4);

        // Reset mid-op with a pending ACC result
        issue("pre_clr",   3'd5, 4'h0, 4'h0, 1'b0, mk(4'h0, 1'b0, 1'b0, 4'h0));
        issue("pend_acc",  3'd4, 4'h5, 4'h0, 1'b0, mk(4'h5, 1'b0, 1'b0, 4'h5));
        out_ready = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {3'b0, out_valid}, 4'h0);
        chk("mid_rst_acc",   acc,               4'h0);
        chk("mid_rst_zero",  {3'b0, zero},      4'h1);
        chk("mid_rst_ready", {3'b0, in_ready},  4'h0);
        exp_q.delete();
        name_q.delete();
        pushed--;
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        issue("post_rst_adc", 3'd2, 4'h1, 4'h1, 1'b0, mk(4'h2, 1'b0, 1'b0, 4'h0));

        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", 4'(exp_q.size()), 4'h0);
        checks++;
        if (popped != pushed) begin
            errors++;
            $display("FAIL result_count: got %0d results expected %0d", popped, pushed);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
